// File: rtl/conv_mem_host.sv
// Host/memory responder for the CONV accelerator.
// Image ROM, two layer banks, start handshake, dump port.
module conv_mem_host #(
  parameter int         ADDR_W      = 12,
  parameter int         DATA_W      = 20,
  parameter int         ARM_TIMEOUT = 1024,
  parameter logic [2:0] CSEL_L0     = 3'b001,
  parameter logic [2:0] CSEL_L1     = 3'b011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              ready,
  input  logic              busy,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  input  logic              cwr,
  input  logic [ADDR_W-1:0] caddr_wr,
  input  logic [DATA_W-1:0] cdata_wr,
  input  logic              crd,
  input  logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_rd,
  input  logic [2:0]        csel,
  input  logic              dump_bank,
  input  logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wr_cnt0,
  output logic [ADDR_W:0]   wr_cnt1
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TW-1:0]   TMO_LAST = TW'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TW-1:0]     r_tmo;
  logic              r_err;
  logic [ADDR_W:0]   r_cnt0;
  logic [ADDR_W:0]   r_cnt1;
  logic [DATA_W-1:0] r_dump;

  logic [DATA_W-1:0] r_img [DEPTH];
  logic [DATA_W-1:0] r_l0  [DEPTH];
  logic [DATA_W-1:0] r_l1  [DEPTH];

  logic w_idle;
  logic w_active;
  logic w_sel0;
  logic w_sel1;
  logic w_selv;
  logic w_start;
  logic w_load;
  logic w_wr0;
  logic w_wr1;
  logic w_tmo_hit;
  logic w_err_set;

  assign w_idle    = (r_state == S_IDLE);
  assign w_active  = (r_state == S_ARM) || (r_state == S_RUN);
  assign w_sel0    = (csel == CSEL_L0);
  assign w_sel1    = (csel == CSEL_L1);
  assign w_selv    = w_sel0 || w_sel1;
  assign w_start   = w_idle && start;
  assign w_load    = w_idle && load_en;
  assign w_wr0     = cwr && w_active && w_sel0;
  assign w_wr1     = cwr && w_active && w_sel1;
  assign w_tmo_hit = (r_state == S_ARM) && !busy
                     && (r_tmo == TMO_LAST);

  assign w_err_set = (load_en && !w_idle)
                   || (cwr && (!w_active || !w_selv))
                   || (crd && !w_selv)
                   || w_tmo_hit;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_ARM;
      S_ARM: begin
        if (busy)           w_next = S_RUN;
        else if (w_tmo_hit) w_next = S_IDLE;
      end
      S_RUN:  if (!busy) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Counts ARM cycles; leaves ARM before it can wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (r_state == S_ARM && w_next == S_ARM) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

  // An error in the start cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (w_start)   r_err <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset || w_start) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_wr0 && r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_wr1 && r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) r_img[load_addr] <= load_data;
    if (w_wr0)  r_l0[caddr_wr]   <= cdata_wr;
    if (w_wr1)  r_l1[caddr_wr]   <= cdata_wr;
  end

  always_ff @(posedge clk) begin
    if (reset)          r_dump <= '0;
    else if (dump_bank) r_dump <= r_l1[dump_addr];
    else                r_dump <= r_l0[dump_addr];
  end

  always_comb begin
    cdata_rd = '0;
    if (crd && w_sel0)      cdata_rd = r_l0[caddr_rd];
    else if (crd && w_sel1) cdata_rd = r_l1[caddr_rd];
  end

  assign idata     = r_img[iaddr];
  assign ready     = (r_state == S_ARM);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign wr_cnt0   = r_cnt0;
  assign wr_cnt1   = r_cnt1;
  assign dump_data = r_dump;

endmodule
